key_entry: RTL and testbench

- Consumes the encoded keypad stream (5-bit key code plus key-present strobe) produced by the keypad synchroniser/encoder.
- Assembles hex digits into a multi-digit operand and handles the function keys (backspace, clear, enter, negate).
- Delivers the finished operand to the downstream input port over a valid/ready handshake.
- Adds release lockout so that one physical press yields exactly one accepted key.

---
 rtl/key_entry.sv | 134 +++++++++++++
 tb/tb_key_entry.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/key_entry.sv
// rtl/key_entry.sv - keypad operand entry with release lockout and valid/ready output
module key_entry #(
    parameter int DIGITS         = 8,
    parameter int RELEASE_CYCLES = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [4:0]                   keycode,
    input  logic                         keyclk,
    output logic [4*DIGITS-1:0]          out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [4*DIGITS-1:0]          disp_val,
    output logic [$clog2(DIGITS+1)-1:0]  digit_cnt,
    output logic                         neg,
    output logic                         overflow,
    output logic                         busy
);

    localparam int W  = 4 * DIGITS;
    localparam int CW = $clog2(DIGITS + 1);

    localparam logic [7:0]    REL_MAX = 8'(RELEASE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DIGITS);

    localparam logic [4:0] K_DIGIT_END = 5'd16;
    localparam logic [4:0] K_BACKSPACE = 5'd16;
    localparam logic [4:0] K_CLEAR     = 5'd17;
    localparam logic [4:0] K_ENTER     = 5'd18;
    localparam logic [4:0] K_NEGATE    = 5'd19;

    typedef enum logic {
        ENTRY,
        SEND
    } state_t;

    state_t     state;
    logic       armed;
    logic [7:0] rel_cnt;
    logic       accept;

    // A press is taken only once the key has been released long enough.
    assign accept = keyclk & armed;

    // Release lockout: count low cycles, re-arm once the count reaches the limit.
    always_ff @(posedge clk) begin
        if (rst) begin
            armed   <= 1'b1;
            rel_cnt <= 8'd0;
        end else if (keyclk) begin
            rel_cnt <= 8'd0;
            armed   <= 1'b0;
        end else if (rel_cnt < REL_MAX) begin
            rel_cnt <= rel_cnt + 8'd1;
            if (rel_cnt + 8'd1 == REL_MAX) begin
                armed <= 1'b1;
            end
        end else begin
            armed <= 1'b1;
        end
    end

    // Entry/send state machine; disp_val doubles as the accumulator.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ENTRY;
            out_data  <= '0;
            out_valid <= 1'b0;
            disp_val  <= '0;
            digit_cnt <= '0;
            neg       <= 1'b0;
            overflow  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                ENTRY: begin
                    if (accept) begin
                        if (keycode < K_DIGIT_END) begin
                            if (digit_cnt < CNT_MAX) begin
                                disp_val  <= {disp_val[W-5:0], keycode[3:0]};
                                digit_cnt <= digit_cnt + CW'(1);
                            end else begin
                                overflow <= 1'b1;
                            end
                        end else begin
                            case (keycode)
                                K_BACKSPACE: begin
                                    if (digit_cnt != '0) begin
                                        disp_val  <= disp_val >> 4;
                                        digit_cnt <= digit_cnt - CW'(1);
                                    end
                                end
                                K_CLEAR: begin
                                    disp_val  <= '0;
                                    digit_cnt <= '0;
                                    neg       <= 1'b0;
                                    overflow  <= 1'b0;
                                end
                                K_ENTER: begin
                                    out_data  <= neg ? (~disp_val + W'(1)) : disp_val;
                                    out_valid <= 1'b1;
                                    busy      <= 1'b1;
                                    state     <= SEND;
                                end
                                K_NEGATE: begin
                                    neg <= ~neg;
                                end
                                default: begin
                                    // Unassigned codes are ignored.
                                end
                            endcase
                        end
                    end
                end
                SEND: begin
                    // Keys here are dropped; the lockout block still consumes armed.
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        disp_val  <= '0;
                        digit_cnt <= '0;
                        neg       <= 1'b0;
                        overflow  <= 1'b0;
                        state     <= ENTRY;
                    end
                end
                default: begin
                    state <= ENTRY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_key_entry.sv
// tb/tb_key_entry.sv - self-checking bench for key_entry
module tb_key_entry;

    logic        clk;
    logic        rst;
    logic [4:0]  keycode;
    logic        keyclk;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] disp_val;
    logic [3:0]  digit_cnt;
    logic        neg;
    logic        overflow;
    logic        busy;

    int errors = 0;
    int checks = 0;

    key_entry #(.DIGITS(8), .RELEASE_CYCLES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .keycode   (keycode),
        .keyclk    (keyclk),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .disp_val  (disp_val),
        .digit_cnt (digit_cnt),
        .neg       (neg),
        .overflow  (overflow),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  code;
        int          hold;
        int          gap;
        logic [31:0] disp;
        logic [3:0]  cnt;
        logic        ng;
        logic        ov;
        logic        vl;
        logic        bs;
        logic [31:0] data;
    } vec_t;

    vec_t tv[40];
    int   nv = 0;

    localparam logic [4:0] BS  = 5'd16;
    localparam logic [4:0] CLR = 5'd17;
    localparam logic [4:0] ENT = 5'd18;
    localparam logic [4:0] NEG = 5'd19;

    task automatic add(input logic [4:0] code, input int hold, input int gap,
                       input logic [31:0] disp, input logic [3:0] cnt,
                       input logic ng, input logic ov, input logic vl,
                       input logic bs, input logic [31:0] data);
        tv[nv].code = code;
        tv[nv].hold = hold;
        tv[nv].gap  = gap;
        tv[nv].disp = disp;
        tv[nv].cnt  = cnt;
        tv[nv].ng   = ng;
        tv[nv].ov   = ov;
        tv[nv].vl   = vl;
        tv[nv].bs   = bs;
        tv[nv].data = data;
        nv++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [31:0] disp, input logic [3:0] cnt,
                           input logic ng, input logic ov, input logic vl,
                           input logic bs, input logic [31:0] data);
        chk({tag, ".disp_val"},  disp_val,           disp);
        chk({tag, ".digit_cnt"}, {28'd0, digit_cnt}, {28'd0, cnt});
        chk({tag, ".neg"},       {31'd0, neg},       {31'd0, ng});
        chk({tag, ".overflow"},  {31'd0, overflow},  {31'd0, ov});
        chk({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, vl});
        chk({tag, ".busy"},      {31'd0, busy},      {31'd0, bs});
        chk({tag, ".out_data"},  out_data,           data);
    endtask

    task automatic run_rows(input int first, input int last);
        for (int i = first; i < last; i++) begin
            keycode = tv[i].code;
            keyclk  = 1'b1;
            for (int h = 0; h < tv[i].hold; h++) step();
            keyclk = 1'b0;
            for (int g = 0; g < tv[i].gap; g++) step();
            chk_all($sformatf("row%0d", i), tv[i].disp, tv[i].cnt, tv[i].ng,
                    tv[i].ov, tv[i].vl, tv[i].bs, tv[i].data);
        end
    endtask

    initial begin
        rst       = 1'b1;
        keycode   = 5'd0;
        keyclk    = 1'b0;
        out_ready = 1'b0;

        // Segment A: basic digits, lockout, negate and held ENTER
        add(5'h1, 3, 5, 32'h1,   4'd1, 0, 0, 0, 0, 32'h0);
        add(5'h2, 3, 5, 32'h12,  4'd2, 0, 0, 0, 0, 32'h0);
        add(5'h3, 3, 5, 32'h123, 4'd3, 0, 0, 0, 0, 32'h0);
        add(CLR,  1, 4, 32'h0,   4'd0, 0, 0, 0, 0, 32'h0);
        add(5'hA, 20, 3, 32'hA,  4'd1, 0, 0, 0, 0, 32'h0);
        add(5'hB, 2, 4, 32'hA,   4'd1, 0, 0, 0, 0, 32'h0);
        add(5'hB, 2, 4, 32'hAB,  4'd2, 0, 0, 0, 0, 32'h0);
        add(CLR,  1, 4, 32'h0,   4'd0, 0, 0, 0, 0, 32'h0);
        add(5'h5, 1, 4, 32'h5,   4'd1, 0, 0, 0, 0, 32'h0);
        add(NEG,  1, 4, 32'h5,   4'd1, 1, 0, 0, 0, 32'h0);
        add(ENT,  1, 4, 32'h5,   4'd1, 1, 0, 1, 1, 32'hFFFFFFFB);
        add(5'h7, 1, 4, 32'h5,   4'd1, 1, 0, 1, 1, 32'hFFFFFFFB);
        // Segment B: overflow, backspace, clear, empty backspace (rows 12..23)
        add(5'h1, 1, 4, 32'h1,        4'd1, 0, 0, 0, 0, 32'hFFFFFFFB);
        add(5'h2, 1, 4, 32'h12,       4'd2, 0, 0, 0, 0, 32'hFFFFFFFB);
        add(5'h3, 1, 4, 32'h123,      4'd3, 0, 0, 0, 0, 32'hFFFFFFFB);
        add(5'h4, 1, 4, 32'h1234,     4'd4, 0, 0, 0, 0, 32'hFFFFFFFB);
        add(5'h5, 1, 4, 32'h12345,    4'd5, 0, 0, 0, 0, 32'hFFFFFFFB);
        add(5'h6, 1, 4, 32'h123456,   4'd6, 0, 0, 0, 0, 32'hFFFFFFFB);
        add(5'h7, 1, 4, 32'h1234567,  4'd7, 0, 0, 0, 0, 32'hFFFFFFFB);
        add(5'h8, 1, 4, 32'h12345678, 4'd8, 0, 0, 0, 0, 32'hFFFFFFFB);
        add(5'h9, 1, 4, 32'h12345678, 4'd8, 0, 1, 0, 0, 32'hFFFFFFFB);
        add(BS,   1, 4, 32'h01234567, 4'd7, 0, 1, 0, 0, 32'hFFFFFFFB);
        add(CLR,  1, 4, 32'h0,        4'd0, 0, 0, 0, 0, 32'hFFFFFFFB);
        add(BS,   1, 4, 32'h0,        4'd0, 0, 0, 0, 0, 32'hFFFFFFFB);
        // Segment C: operand pending when reset arrives (rows 24..25)
        add(5'h3, 1, 4, 32'h3,   4'd1, 0, 0, 0, 0, 32'h0);
        add(ENT,  1, 4, 32'h3,   4'd1, 0, 0, 1, 1, 32'h3);

        step();
        step();
        chk_all("reset", 32'h0, 4'd0, 0, 0, 0, 0, 32'h0);
        rst = 1'b0;
        step();
        chk_all("post_reset", 32'h0, 4'd0, 0, 0, 0, 0, 32'h0);

        run_rows(0, 12);

        // Handshake completes on the first edge with out_ready high
        out_ready = 1'b1;
        step();
        chk_all("handshake", 32'h0, 4'd0, 0, 0, 0, 0, 32'hFFFFFFFB);
        out_ready = 1'b0;
        for (int g = 0; g < 4; g++) step();

        run_rows(12, 24);

        // ENTER on empty entry with out_ready already high: one-cycle valid
        out_ready = 1'b1;
        keycode   = ENT;
        keyclk    = 1'b1;
        step();
        chk_all("empty_enter", 32'h0, 4'd0, 0, 0, 1, 1, 32'h0);
        keyclk = 1'b0;
        step();
        chk_all("empty_enter_done", 32'h0, 4'd0, 0, 0, 0, 0, 32'h0);
        out_ready = 1'b0;
        for (int g = 0; g < 4; g++) step();

        run_rows(24, 26);

        // Reset while the operand is waiting drops it
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_all("rst_in_send", 32'h0, 4'd0, 0, 0, 0, 0, 32'h0);
        step();
        chk_all("rst_in_send_hold", 32'h0, 4'd0, 0, 0, 0, 0, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
